// File: rtl/codec_pkg.sv
// -----------------------------------------------------------------------------
// codec_pkg
// Shared constants and types for the CS4272 serial audio interface.
//
// Contents:
//   SAMPLE_W / CNT_W        : sample and frame-counter widths
//   CNT_RST                 : frame counter value held in reset (start of left slot)
//   *_PHASE / *_CNT         : counter values that trigger receive, transmit,
//                             word-complete and valid events
//   WARMUP_FRAMES / WARM_W  : number of muted frames after codec reset release
//                             (only used when CODEC_WARMUP_EN is defined)
//   sample_t                : signed audio sample
//   strobe_t                : one-cycle event strobes decoded from the counter
// -----------------------------------------------------------------------------
package codec_pkg;

    localparam int SAMPLE_W = 16;
    localparam int CNT_W    = 10;

    localparam logic [CNT_W-1:0] CNT_RST         = 10'h200;
    localparam logic [4:0]       RX_SAMPLE_PHASE = 5'b01111;
    localparam logic [4:0]       TX_SHIFT_PHASE  = 5'b11111;
    localparam logic [CNT_W-1:0] VALID_CNT       = 10'h1F0;
    localparam logic [CNT_W-1:0] LFT_DONE_CNT    = 10'h3EF;
    localparam logic [CNT_W-1:0] RGT_DONE_CNT    = 10'h1EF;
    localparam logic [CNT_W-1:0] TX_LOAD_CNT     = 10'h1FF;
    localparam logic [CNT_W-1:0] FRAME_END_CNT   = 10'h3FF;

    localparam int              WARMUP_FRAMES = 4;
    localparam int              WARM_W        = 3;
    localparam logic [WARM_W-1:0] WARM_DONE   = WARM_W'(WARMUP_FRAMES);

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef struct packed {
        logic rx_sample;   // SCLK about to rise: sample SDout
        logic tx_shift;    // SCLK about to fall: advance SDin
        logic tx_load;     // last cycle of right slot: load new transmit frame
        logic lft_done;    // last left bit being sampled
        logic rgt_done;    // last right bit being sampled
        logic valid_cyc;   // cycle in which valid is presented
        logic frame_end;   // last cycle of left slot (LRCLK about to fall)
    } strobe_t;

    // True when the low five counter bits match a bit-clock phase.
    function automatic logic phase_hit(input logic [CNT_W-1:0] cnt,
                                       input logic [4:0]       phase);
        return (cnt[4:0] == phase);
    endfunction

endpackage

// File: rtl/codec_clkgen.sv
// -----------------------------------------------------------------------------
// codec_clkgen
// Free-running 10-bit frame counter and the codec clocks derived from it.
// All clocks are plain register bits of the counter, so they are glitch-free.
//
// Ports:
//   i_clk     in   50 MHz system clock
//   i_rst_n   in   asynchronous active-low reset (counter -> CNT_RST)
//   o_mclk    out  codec master clock, clk/4   (cnt[1])
//   o_sclk    out  serial bit clock,   clk/32  (cnt[4])
//   o_lrclk   out  frame clock,        clk/1024 (cnt[9], 1 = left slot)
//   o_stb     out  one-cycle event strobes decoded from the counter
// -----------------------------------------------------------------------------
module codec_clkgen
    import codec_pkg::*;
(
    input  logic    i_clk,
    input  logic    i_rst_n,
    output logic    o_mclk,
    output logic    o_sclk,
    output logic    o_lrclk,
    output strobe_t o_stb
);

    logic [CNT_W-1:0] r_cnt;

    // Reset value 0x200 places the interface at the start of a left slot
    // with LRCLK high and both bit clocks low.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= CNT_RST;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_mclk  = r_cnt[1];
    assign o_sclk  = r_cnt[4];
    assign o_lrclk = r_cnt[9];

    always_comb begin
        o_stb           = '0;
        o_stb.rx_sample = phase_hit(r_cnt, RX_SAMPLE_PHASE);
        o_stb.tx_shift  = phase_hit(r_cnt, TX_SHIFT_PHASE);
        o_stb.tx_load   = (r_cnt == TX_LOAD_CNT);
        o_stb.lft_done  = (r_cnt == LFT_DONE_CNT);
        o_stb.rgt_done  = (r_cnt == RGT_DONE_CNT);
        o_stb.valid_cyc = (r_cnt == VALID_CNT);
        o_stb.frame_end = (r_cnt == FRAME_END_CNT);
    end

endmodule

// File: rtl/codec_intf.sv
// -----------------------------------------------------------------------------
// codec_intf
// Serial audio interface to the CS4272 codec. Generates MCLK/SCLK/LRCLK,
// deserializes left-justified 16-bit SDout samples into lft_in/rht_in with a
// one-cycle valid strobe, and serializes lft_out/rht_out onto SDin.
//
// Optional feature: define CODEC_WARMUP_EN to mute the interface (no valid,
// SDin zeros) for the first WARMUP_FRAMES frames after RSTn rises.
//
// Ports:
//   clk      in   50 MHz system clock
//   rst_n    in   asynchronous active-low reset
//   lft_out  in   signed left sample to transmit, captured while valid=1
//   rht_out  in   signed right sample to transmit, captured while valid=1
//   SDout    in   serial data from codec ADC
//   MCLK     out  codec master clock, clk/4
//   SCLK     out  serial bit clock, clk/32
//   LRCLK    out  frame clock, clk/1024 (1 = left slot)
//   RSTn     out  codec reset, active low
//   SDin     out  serial data to codec DAC
//   lft_in   out  signed left sample received
//   rht_in   out  signed right sample received
//   valid    out  one-clk pulse: lft_in/rht_in updated, lft_out/rht_out captured
// -----------------------------------------------------------------------------
module codec_intf
    import codec_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic signed [SAMPLE_W-1:0] lft_out,
    input  logic signed [SAMPLE_W-1:0] rht_out,
    input  logic                       SDout,
    output logic                       MCLK,
    output logic                       SCLK,
    output logic                       LRCLK,
    output logic                       RSTn,
    output logic                       SDin,
    output logic signed [SAMPLE_W-1:0] lft_in,
    output logic signed [SAMPLE_W-1:0] rht_in,
    output logic                       valid
);

    strobe_t               w_stb;
    logic [SAMPLE_W-1:0]   w_rx_word;
    logic                  w_live;

    logic [SAMPLE_W-1:0]   r_rx_shift;
    logic [SAMPLE_W-1:0]   r_lft_shadow;
    sample_t               r_lft_in;
    sample_t               r_rht_in;
    logic                  r_valid;
    logic [2*SAMPLE_W-1:0] r_tx_hold;
    logic [2*SAMPLE_W-1:0] r_tx_shift;
    logic                  r_rstn;

    codec_clkgen u_clkgen (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .o_mclk  (MCLK),
        .o_sclk  (SCLK),
        .o_lrclk (LRCLK),
        .o_stb   (w_stb)
    );

    // Word as it will stand once the current SDout bit is shifted in; used
    // so the final bit of a slot can be captured in the same cycle.
    assign w_rx_word = {r_rx_shift[SAMPLE_W-2:0], SDout};

`ifdef CODEC_WARMUP_EN
    logic [WARM_W-1:0] r_warm_cnt;

    // Counts valid points seen after the codec left reset, saturating once
    // the muted warm-up frames are over.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_warm_cnt <= '0;
        end else if (w_stb.valid_cyc && r_rstn && (r_warm_cnt != WARM_DONE)) begin
            r_warm_cnt <= r_warm_cnt + 1'b1;
        end
    end

    assign w_live = (r_warm_cnt == WARM_DONE);
`else
    assign w_live = 1'b1;
`endif

    // Receive path: shift on SCLK rise, park the left word until the right
    // word completes so both are presented together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_shift   <= '0;
            r_lft_shadow <= '0;
        end else begin
            if (w_stb.rx_sample) begin
                r_rx_shift <= w_rx_word;
            end
            if (w_stb.lft_done) begin
                r_lft_shadow <= w_rx_word;
            end
        end
    end

    // Parallel outputs are registered on the last right-bit sample so that
    // they and valid are visible during the VALID_CNT cycle. Samples still
    // update while the warm-up mute is active; only valid is withheld.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lft_in <= '0;
            r_rht_in <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= w_stb.rgt_done & w_live;
            if (w_stb.rgt_done) begin
                r_lft_in <= sample_t'(r_lft_shadow);
                r_rht_in <= sample_t'(w_rx_word);
            end
        end
    end

    // Transmit path: capture in the valid cycle, load at the left-slot
    // boundary, and advance only on SCLK falling so SDin is stable across
    // every rising edge. The load takes priority over the shift that shares
    // the same phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_hold  <= '0;
            r_tx_shift <= '0;
        end else begin
            if (w_stb.valid_cyc) begin
                r_tx_hold <= w_live ? {lft_out, rht_out} : '0;
            end
            if (w_stb.tx_load) begin
                r_tx_shift <= r_tx_hold;
            end else if (w_stb.tx_shift) begin
                r_tx_shift <= {r_tx_shift[2*SAMPLE_W-2:0], 1'b0};
            end
        end
    end

    // Codec reset is released at the first LRCLK falling edge and stays
    // released until the next system reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rstn <= 1'b0;
        end else if (w_stb.frame_end) begin
            r_rstn <= 1'b1;
        end
    end

    assign RSTn   = r_rstn;
    assign SDin   = r_tx_shift[2*SAMPLE_W-1];
    assign lft_in = r_lft_in;
    assign rht_in = r_rht_in;
    assign valid  = r_valid;

endmodule

// File: tb/tb_codec_intf.sv
// -----------------------------------------------------------------------------
// tb_codec_intf
// Scoreboard bench for codec_intf. A behavioural codec model drives SDout
// slot by slot and queues the sample pair each frame should deliver; a
// monitor pops and compares on every valid and answers with lft_out/rht_out;
// a serial collector rebuilds SDin frames at SCLK rises and compares them
// with the pairs captured one frame earlier.
// -----------------------------------------------------------------------------
module tb_codec_intf;

`ifdef CODEC_WARMUP_EN
    localparam int WARM = 4;
`else
    localparam int WARM = 0;
`endif
    localparam int FRAME       = 1024;
    localparam int FIRST_VALID = 1008;
    localparam int RSTN_DELAY  = 512;

    localparam int M_FIXED = 0;
    localparam int M_RAND  = 1;
    localparam int M_LOOP  = 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic signed [15:0] lft_out = '0;
    logic signed [15:0] rht_out = '0;
    logic               SDout;
    logic               MCLK, SCLK, LRCLK, RSTn, SDin;
    logic signed [15:0] lft_in, rht_in;
    logic               valid;

    logic               codec_sd = 1'b0;
    int                 mode = M_FIXED;

    assign SDout = (mode == M_LOOP) ? SDin : codec_sd;

    codec_intf dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .lft_out (lft_out),
        .rht_out (rht_out),
        .SDout   (SDout),
        .MCLK    (MCLK),
        .SCLK    (SCLK),
        .LRCLK   (LRCLK),
        .RSTn    (RSTn),
        .SDin    (SDin),
        .lft_in  (lft_in),
        .rht_in  (rht_in),
        .valid   (valid)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] rxq[$];
    logic [31:0] txq[$];

    int cyc = 0;
    int nvalid = 0;
    int exp_total = 0;
    int clk_bad = 0;
    int ctl_bad = 0;
    int n_medge = 0, n_sedge = 0, n_ledge = 0, n_txf = 0;

    // monitor history
    int   last_v = -1;
    int   mclk_t = -1, sclk_t = -1, lrclk_t = -1;
    logic valid_q = 1'b0, mclk_q = 1'b0, sclk_q = 1'b0, lrclk_q = 1'b1, sd_q = 1'b0;
    logic rstn_seen = 1'b0;

    // codec model state
    logic [15:0] cw_l = '0, cw_r = '0;
    int          bitn = 0;
    int          frame_no = 0;
    logic        prev_lr = 1'b1;

    // serial collector state
    logic [31:0] txbits = '0;
    int          txn = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] pick_word(input logic left);
        if (mode == M_FIXED) return left ? 16'h1234 : 16'hA5A5;
        return 16'($urandom);
    endfunction

    function automatic int exp_valids(input int len);
        int n;
        if (len < FIRST_VALID) return 0;
        n = (len - FIRST_VALID) / FRAME + 1 - WARM;
        return (n < 0) ? 0 : n;
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_MCLK"},   {31'b0, MCLK},   32'd0);
        check({tag, "_SCLK"},   {31'b0, SCLK},   32'd0);
        check({tag, "_LRCLK"},  {31'b0, LRCLK},  32'd1);
        check({tag, "_RSTn"},   {31'b0, RSTn},   32'd0);
        check({tag, "_SDin"},   {31'b0, SDin},   32'd0);
        check({tag, "_lft_in"}, {16'b0, lft_in}, 32'd0);
        check({tag, "_rht_in"}, {16'b0, rht_in}, 32'd0);
        check({tag, "_valid"},  {31'b0, valid},  32'd0);
    endtask

    // Restart every model at a reset release. The interface starts in the
    // first bit of a left slot with all transmit state cleared.
    task automatic release_reset();
        @(negedge clk);
        cyc = 0;
        last_v = -1; valid_q = 1'b0; rstn_seen = 1'b0;
        mclk_t = -1; sclk_t = -1; lrclk_t = -1;
        mclk_q = 1'b0; sclk_q = 1'b0; lrclk_q = 1'b1; sd_q = 1'b0;
        rxq.delete(); txq.delete();
        txn = 0; txbits = '0;
        prev_lr = 1'b1; bitn = 0; frame_no = 0;
        cw_l = pick_word(1'b1);
        codec_sd = cw_l[15];
        // In loopback the first frame echoes the all-zero reset transmit.
        if (mode == M_LOOP) rxq.push_back(32'h0);
        rst_n = 1'b1;
    endtask

    initial begin : cycle_count
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Codec ADC model: left-justified, MSB first, new bit after each SCLK fall.
    initial begin : codec_model
        forever begin
            @(negedge SCLK);
            #1;
            if (rst_n) begin
                if (LRCLK !== prev_lr) begin
                    prev_lr = LRCLK;
                    bitn = 0;
                    if (LRCLK) begin
                        cw_l = pick_word(1'b1);
                    end else begin
                        cw_r = pick_word(1'b0);
                        frame_no++;
                        if (mode != M_LOOP && frame_no > WARM) rxq.push_back({cw_l, cw_r});
                    end
                end else begin
                    bitn++;
                end
                if (bitn < 16) codec_sd = LRCLK ? cw_l[15-bitn] : cw_r[15-bitn];
                else           codec_sd = 1'b0;
            end
        end
    end

    // Codec DAC model: rebuild 32-bit frames from SDin at SCLK rises.
    initial begin : tx_collect
        logic [31:0] e;
        forever begin
            @(posedge SCLK);
            if (rst_n) begin
                txbits = {txbits[30:0], SDin};
                txn++;
                if (txn == 32) begin
                    txn = 0;
                    n_txf++;
                    e = (txq.size() > 0) ? txq.pop_front() : 32'h0;
                    check("tx_serial", txbits, e);
                end
            end
        end
    end

    // Monitor and responder, sampled on the falling clock edge.
    initial begin : monitor
        logic [31:0]        e;
        logic signed [15:0] lo, ro;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (MCLK && !mclk_q) begin
                    if (mclk_t >= 0 && cyc - mclk_t != 4) clk_bad++;
                    mclk_t = cyc; n_medge++;
                end
                if (SCLK && !sclk_q) begin
                    if (sclk_t >= 0 && cyc - sclk_t != 32) clk_bad++;
                    sclk_t = cyc; n_sedge++;
                end
                if (LRCLK && !lrclk_q) begin
                    if (lrclk_t >= 0 && cyc - lrclk_t != FRAME) clk_bad++;
                    lrclk_t = cyc; n_ledge++;
                end
                if (RSTn && !rstn_seen) begin
                    rstn_seen = 1'b1;
                    check("rstn_rise_delay", cyc, RSTN_DELAY);
                end else if (!RSTn && rstn_seen) begin
                    ctl_bad++;
                end
                if (SDin !== sd_q && !(sclk_q && !SCLK)) ctl_bad++;
                if (valid) begin
                    nvalid++;
                    if (valid_q) ctl_bad++;
                    if (last_v < 0) check("first_valid_delay", cyc, FIRST_VALID + FRAME * WARM);
                    else            check("valid_period", cyc - last_v, FRAME);
                    last_v = cyc;
                    if (rxq.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL rx_samples: got valid with %h_%h, expected no valid", lft_in, rht_in);
                    end else begin
                        e = rxq.pop_front();
                        check("rx_samples", {lft_in, rht_in}, e);
                    end
                    case (mode)
                        M_FIXED: begin lo = 16'sh8001;     ro = 16'sh7FFE;    end
                        M_LOOP:  begin lo = lft_in + 16'sd1; ro = 16'($urandom); end
                        default: begin lo = 16'($urandom);  ro = 16'($urandom); end
                    endcase
                    lft_out = lo;
                    rht_out = ro;
                    txq.push_back({lo, ro});
                    if (mode == M_LOOP) rxq.push_back({lo, ro});
                end else begin
                    // Garbage outside the valid cycle must never be captured.
                    lft_out = 16'($urandom);
                    rht_out = 16'($urandom);
                end
                valid_q = valid; mclk_q = MCLK; sclk_q = SCLK; lrclk_q = LRCLK; sd_q = SDin;
            end
        end
    end

    initial begin : stimulus
        logic got;
        logic lr_prev;
        mode = M_FIXED;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_reset_vals("por");

        release_reset();
        repeat (FIRST_VALID + FRAME * (WARM + 3) + 10) @(posedge clk);
        mode = M_RAND;
        repeat (FRAME * 6) @(posedge clk);

        // Reset in the middle of a left slot (about cnt 0x2A0).
        got = 1'b0;
        lr_prev = LRCLK;
        for (int i = 0; i < 2 * FRAME && !got; i++) begin
            @(posedge clk);
            #1;
            if (LRCLK && !lr_prev) got = 1'b1;
            lr_prev = LRCLK;
        end
        check("lrclk_rise_seen", {31'b0, got}, 32'd1);
        repeat (160) @(posedge clk);
        #3;
        exp_total += exp_valids(cyc);
        rst_n = 1'b0;
        #1 check_reset_vals("mid");
        mode = M_LOOP;
        repeat (5) @(posedge clk);

        release_reset();
        repeat (FIRST_VALID + FRAME * (WARM + 30) + 10) @(posedge clk);
        #6;
        exp_total += exp_valids(cyc);

        check("valid_count", nvalid, exp_total);
        check("clock_period_errors", clk_bad, 32'd0);
        check("control_errors", ctl_bad, 32'd0);
        check("mclk_edges_seen", (n_medge > 1000) ? 32'd1 : 32'd0, 32'd1);
        check("sclk_edges_seen", (n_sedge > 100) ? 32'd1 : 32'd0, 32'd1);
        check("lrclk_edges_seen", (n_ledge > 20) ? 32'd1 : 32'd0, 32'd1);
        check("tx_frames_seen", (n_txf > 20) ? 32'd1 : 32'd0, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
